// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage: datapath width, load sizes and
// the pipeline register layout.
package mem_wb_stage_pkg;

  localparam int LARGURA = 32;
  localparam int NUM_REGS = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    TAM_BYTE      = 2'b00,
    TAM_HALF      = 2'b01,
    TAM_WORD      = 2'b10,
    TAM_RESERVADO = 2'b11
  } tamanho_e;

  typedef struct packed {
    logic               valido;
    logic               escreverReg;
    logic               memParaReg;
    tamanho_e           tamanhoLoad;
    logic               loadComSinal;
    logic [4:0]         regDestino;
    logic [LARGURA-1:0] aluResultado;
    logic [LARGURA-1:0] saida;
  } memWb_t;

endpackage

// File: rtl/mem_wb_stage_banco_registradores.sv
// Register file: one write port, two combinational read ports with
// write-through bypass; entry 0 is hard-wired to zero.
module banco_registradores #(
  parameter int LARGURA  = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              escrever,
  input  logic [ADDR_W-1:0] enderecoEscrita,
  input  logic [LARGURA-1:0] dadoEscrita,
  input  logic [ADDR_W-1:0] enderecoLeitura1,
  input  logic [ADDR_W-1:0] enderecoLeitura2,
  output logic [LARGURA-1:0] dadoLeitura1,
  output logic [LARGURA-1:0] dadoLeitura2
);

  logic [LARGURA-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (escrever && enderecoEscrita != '0) begin
      regs[enderecoEscrita] <= dadoEscrita;
    end
  end

  // Bypass lets ID see the WB result in the same cycle it is being written.
  always_comb begin
    dadoLeitura1 = '0;
    if (enderecoLeitura1 != '0) begin
      dadoLeitura1 = (escrever && enderecoLeitura1 == enderecoEscrita) ?
                     dadoEscrita : regs[enderecoLeitura1];
    end
  end

  always_comb begin
    dadoLeitura2 = '0;
    if (enderecoLeitura2 != '0) begin
      dadoLeitura2 = (escrever && enderecoLeitura2 == enderecoEscrita) ?
                     dadoEscrita : regs[enderecoLeitura2];
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register, load-data extraction, write-back select and
// register file ownership for the 32-bit pipelined datapath.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int LARGURA  = 32,
  parameter int NUM_REGS = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               congelar,
  input  logic               descartar,
  input  logic               memValido,
  input  logic [LARGURA-1:0] saida,
  input  logic [LARGURA-1:0] aluResultado,
  input  logic [4:0]         regDestino,
  input  logic               escreverReg,
  input  logic               memParaReg,
  input  logic [1:0]         tamanhoLoad,
  input  logic               loadComSinal,
  input  logic [4:0]         regLeitura1,
  input  logic [4:0]         regLeitura2,
  output logic [LARGURA-1:0] dados1,
  output logic [LARGURA-1:0] dados2,
  output logic               wbEscrever,
  output logic [4:0]         wbRegDestino,
  output logic [LARGURA-1:0] wbDado
);

  memWb_t             memWb;
  logic [7:0]         byteSel;
  logic [15:0]        halfSel;
  logic [LARGURA-1:0] loadDado;

  // Flush only kills the write side; the remaining fields are don't-care.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      memWb <= '0;
    end else if (descartar) begin
      memWb.valido      <= 1'b0;
      memWb.escreverReg <= 1'b0;
    end else if (!congelar) begin
      memWb.valido       <= memValido;
      memWb.escreverReg  <= escreverReg;
      memWb.memParaReg   <= memParaReg;
      memWb.tamanhoLoad  <= tamanho_e'(tamanhoLoad);
      memWb.loadComSinal <= loadComSinal;
      memWb.regDestino   <= regDestino;
      memWb.aluResultado <= aluResultado;
      memWb.saida        <= saida;
    end
  end

  always_comb begin
    byteSel  = memWb.saida[{memWb.aluResultado[1:0], 3'b000} +: 8];
    halfSel  = memWb.aluResultado[1] ? memWb.saida[31:16] : memWb.saida[15:0];
    loadDado = memWb.saida;
    case (memWb.tamanhoLoad)
      TAM_BYTE: loadDado = {{(LARGURA-8){memWb.loadComSinal & byteSel[7]}}, byteSel};
      TAM_HALF: loadDado = {{(LARGURA-16){memWb.loadComSinal & halfSel[15]}}, halfSel};
      default:  loadDado = memWb.saida;
    endcase
  end

  assign wbDado       = memWb.memParaReg ? loadDado : memWb.aluResultado;
  assign wbRegDestino = memWb.regDestino;
  assign wbEscrever   = memWb.valido & memWb.escreverReg & (memWb.regDestino != REG_ZERO);

  banco_registradores #(
    .LARGURA (LARGURA),
    .NUM_REGS(NUM_REGS)
  ) uBanco (
    .clock           (clock),
    .reset           (reset),
    .escrever        (wbEscrever),
    .enderecoEscrita (wbRegDestino),
    .dadoEscrita     (wbDado),
    .enderecoLeitura1(regLeitura1),
    .enderecoLeitura2(regLeitura2),
    .dadoLeitura1    (dados1),
    .dadoLeitura2    (dados2)
  );

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clock;
  logic        reset;
  logic        congelar;
  logic        descartar;
  logic        memValido;
  logic [31:0] saida;
  logic [31:0] aluResultado;
  logic [4:0]  regDestino;
  logic        escreverReg;
  logic        memParaReg;
  logic [1:0]  tamanhoLoad;
  logic        loadComSinal;
  logic [4:0]  regLeitura1;
  logic [4:0]  regLeitura2;
  logic [31:0] dados1;
  logic [31:0] dados2;
  logic        wbEscrever;
  logic [4:0]  wbRegDestino;
  logic [31:0] wbDado;

  int total = 0;
  int bad   = 0;

  mem_wb_stage #(.LARGURA(32), .NUM_REGS(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .congelar    (congelar),
    .descartar   (descartar),
    .memValido   (memValido),
    .saida       (saida),
    .aluResultado(aluResultado),
    .regDestino  (regDestino),
    .escreverReg (escreverReg),
    .memParaReg  (memParaReg),
    .tamanhoLoad (tamanhoLoad),
    .loadComSinal(loadComSinal),
    .regLeitura1 (regLeitura1),
    .regLeitura2 (regLeitura2),
    .dados1      (dados1),
    .dados2      (dados2),
    .wbEscrever  (wbEscrever),
    .wbRegDestino(wbRegDestino),
    .wbDado      (wbDado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic idle();
    congelar     = 1'b0;
    descartar    = 1'b0;
    memValido    = 1'b0;
    saida        = '0;
    aluResultado = '0;
    regDestino   = '0;
    escreverReg  = 1'b0;
    memParaReg   = 1'b0;
    tamanhoLoad  = 2'b10;
    loadComSinal = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic m2r, input logic [1:0] tam, input logic sgn);
    memValido    = 1'b1;
    escreverReg  = 1'b1;
    regDestino   = rd;
    aluResultado = alu;
    saida        = rdata;
    memParaReg   = m2r;
    tamanhoLoad  = tam;
    loadComSinal = sgn;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    regLeitura1 = 5'd0;
    regLeitura2 = 5'd0;
    #1;
    total++;
    if (wbEscrever !== 1'b0) begin bad++; $display("FAIL reset_wbEscrever got %b want 0", wbEscrever); end
    total++;
    if (wbDado !== 32'h0) begin bad++; $display("FAIL reset_wbDado got %h want 0", wbDado); end
    total++;
    if (wbRegDestino !== 5'd0) begin bad++; $display("FAIL reset_wbRegDestino got %0d want 0", wbRegDestino); end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      regLeitura1 = 5'(i);
      regLeitura2 = 5'(31 - i);
      #1;
      total++;
      if (dados1 !== 32'h0) begin bad++; $display("FAIL reset_read1 r%0d got %h want 0", i, dados1); end
      total++;
      if (dados2 !== 32'h0) begin bad++; $display("FAIL reset_read2 r%0d got %h want 0", 31 - i, dados2); end
    end
  endtask

  task automatic test_alu_wb();
    @(negedge clock);
    issue(5'd5, 32'd100, 32'hDEAD_BEEF, 1'b0, 2'b10, 1'b0);
    regLeitura1 = 5'd5;
    regLeitura2 = 5'd6;
    @(posedge clock); #1;
    total++;
    if (wbDado !== 32'd100) begin bad++; $display("FAIL alu_wbDado got %h want %h", wbDado, 32'd100); end
    total++;
    if (wbEscrever !== 1'b1 || wbRegDestino !== 5'd5) begin
      bad++; $display("FAIL alu_wbCtrl got en=%b rd=%0d want en=1 rd=5", wbEscrever, wbRegDestino);
    end
    total++;
    if (dados1 !== 32'd100) begin bad++; $display("FAIL alu_bypass got %h want %h", dados1, 32'd100); end
    total++;
    if (dados2 !== 32'h0) begin bad++; $display("FAIL alu_otherReg got %h want 0", dados2); end
    @(negedge clock);
    idle();
    @(posedge clock); #1;
    total++;
    if (wbEscrever !== 1'b0) begin bad++; $display("FAIL alu_bubble got %b want 0", wbEscrever); end
    total++;
    if (dados1 !== 32'd100) begin bad++; $display("FAIL alu_stored got %h want %h", dados1, 32'd100); end
  endtask

  task automatic test_loads();
    logic [1:0]  tamT [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    logic [1:0]  offT [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd0, 2'd3, 2'd2};
    logic        sgnT [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] expT [8] = '{32'hFFFF_FF82, 32'h0000_007F, 32'hFFFF_80F1, 32'h80F1_7F82,
                              32'hFFFF_FF80, 32'h0000_7F82, 32'h0000_80F1, 32'h80F1_7F82};
    regLeitura2 = 5'd7;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      issue(5'd7, {30'h0000_0800, offT[i]}, 32'h80F1_7F82, 1'b1, tamT[i], sgnT[i]);
      @(posedge clock); #1;
      total++;
      if (wbDado !== expT[i]) begin bad++; $display("FAIL load_%0d wbDado got %h want %h", i, wbDado, expT[i]); end
      total++;
      if (dados2 !== expT[i]) begin bad++; $display("FAIL load_%0d bypass got %h want %h", i, dados2, expT[i]); end
    end
    @(negedge clock);
    idle();
    @(posedge clock); #1;
    total++;
    if (dados2 !== 32'h80F1_7F82) begin bad++; $display("FAIL load_stored got %h want 80f17f82", dados2); end
  endtask

  task automatic test_zero();
    @(negedge clock);
    issue(5'd0, 32'd55, 32'h0, 1'b0, 2'b10, 1'b0);
    regLeitura1 = 5'd0;
    regLeitura2 = 5'd0;
    @(posedge clock); #1;
    total++;
    if (wbEscrever !== 1'b0) begin bad++; $display("FAIL zero_wbEscrever got %b want 0", wbEscrever); end
    total++;
    if (dados1 !== 32'h0) begin bad++; $display("FAIL zero_bypass got %h want 0", dados1); end
    @(negedge clock);
    idle();
    @(posedge clock); #1;
    total++;
    if (dados2 !== 32'h0) begin bad++; $display("FAIL zero_stored got %h want 0", dados2); end
  endtask

  task automatic test_stall_flush();
    @(negedge clock);
    issue(5'd3, 32'd7, 32'h0, 1'b0, 2'b10, 1'b0);
    @(posedge clock); #1;
    total++;
    if (wbRegDestino !== 5'd3 || wbDado !== 32'd7) begin
      bad++; $display("FAIL stall_capture got rd=%0d d=%h want rd=3 d=7", wbRegDestino, wbDado);
    end
    @(negedge clock);
    congelar = 1'b1;
    issue(5'd8, 32'd11, 32'h0, 1'b0, 2'b10, 1'b0);
    regLeitura1 = 5'd3;
    regLeitura2 = 5'd8;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if (wbEscrever !== 1'b1 || wbRegDestino !== 5'd3 || wbDado !== 32'd7) begin
      bad++; $display("FAIL stall_hold got en=%b rd=%0d d=%h want en=1 rd=3 d=7", wbEscrever, wbRegDestino, wbDado);
    end
    total++;
    if (dados1 !== 32'd7) begin bad++; $display("FAIL stall_r3 got %h want 7", dados1); end
    total++;
    if (dados2 !== 32'h0) begin bad++; $display("FAIL stall_r8 got %h want 0", dados2); end
    @(negedge clock);
    congelar  = 1'b0;
    descartar = 1'b1;
    issue(5'd4, 32'd9, 32'h0, 1'b0, 2'b10, 1'b0);
    regLeitura1 = 5'd4;
    regLeitura2 = 5'd3;
    @(posedge clock); #1;
    total++;
    if (wbEscrever !== 1'b0) begin bad++; $display("FAIL flush_bubble got %b want 0", wbEscrever); end
    total++;
    if (dados1 !== 32'h0) begin bad++; $display("FAIL flush_r4 got %h want 0", dados1); end
    total++;
    if (dados2 !== 32'd7) begin bad++; $display("FAIL flush_r3 got %h want 7", dados2); end
    @(negedge clock);
    descartar = 1'b0;
    issue(5'd10, 32'd20, 32'h0, 1'b0, 2'b10, 1'b0);
    @(posedge clock); #1;
    total++;
    if (wbEscrever !== 1'b1 || wbRegDestino !== 5'd10) begin
      bad++; $display("FAIL flush_r10 got en=%b rd=%0d want en=1 rd=10", wbEscrever, wbRegDestino);
    end
    @(negedge clock);
    descartar = 1'b1;
    congelar  = 1'b1;
    issue(5'd4, 32'd9, 32'h0, 1'b0, 2'b10, 1'b0);
    regLeitura1 = 5'd4;
    regLeitura2 = 5'd10;
    @(posedge clock); #1;
    total++;
    if (wbEscrever !== 1'b0) begin bad++; $display("FAIL both_bubble got %b want 0", wbEscrever); end
    total++;
    if (dados2 !== 32'd20) begin bad++; $display("FAIL both_r10 got %h want %h", dados2, 32'd20); end
    @(negedge clock);
    idle();
    @(posedge clock); #1;
    total++;
    if (dados1 !== 32'h0) begin bad++; $display("FAIL both_r4 got %h want 0", dados1); end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    issue(5'd6, 32'd66, 32'h0, 1'b0, 2'b10, 1'b0);
    regLeitura1 = 5'd6;
    regLeitura2 = 5'd3;
    @(posedge clock); #1;
    total++;
    if (wbEscrever !== 1'b1 || dados1 !== 32'd66) begin
      bad++; $display("FAIL arst_pending got en=%b d=%h want en=1 d=%h", wbEscrever, dados1, 32'd66);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (wbEscrever !== 1'b0 || wbDado !== 32'h0 || wbRegDestino !== 5'd0) begin
      bad++; $display("FAIL arst_outputs got en=%b rd=%0d d=%h want 0 0 0", wbEscrever, wbRegDestino, wbDado);
    end
    total++;
    if (dados1 !== 32'h0) begin bad++; $display("FAIL arst_r6 got %h want 0", dados1); end
    total++;
    if (dados2 !== 32'h0) begin bad++; $display("FAIL arst_r3 got %h want 0", dados2); end
    @(negedge clock);
    idle();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;
    total++;
    if (dados1 !== 32'h0) begin bad++; $display("FAIL arst_r6_after got %h want 0", dados1); end
    total++;
    if (wbEscrever !== 1'b0) begin bad++; $display("FAIL arst_wbEscrever_after got %b want 0", wbEscrever); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_wb();
    test_loads();
    test_zero();
    test_stall_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
